// File: rtl/rca_8bit_adder_pkg.sv
// Shared constants and result type for the registered ripple-carry adder.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rca_8bit_adder_pkg;

  // Operand width; the adder ports are fixed at this width.
  localparam int ADD_W = 8;

  // Full adder result: carry-out above the sum bits, so {c, s} reads as one number.
  typedef struct packed {
    logic             c;
    logic [ADD_W-1:0] s;
  } add_res_t;

endpackage : rca_8bit_adder_pkg

// File: rtl/rca_8bit_adder_full_adder.sv
// One-bit full adder used as a single stage of the ripple chain.
// Latency: purely combinational, zero cycles.
// Backpressure: none; it is a combinational leaf.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_p;

  // The propagate term is shared by the sum and the carry equations.
  assign w_p  = a ^ b;
  assign sum  = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule : full_adder

// File: rtl/rca_8bit_adder.sv
// Registered 8-bit ripple-carry adder: {c, s} = a + b + c0.
// Latency: one cycle from sampled operands to s/c/out_valid.
// Backpressure: none; every in_valid cycle is accepted and overwrites the result.
module rca_8bit_adder
  import rca_8bit_adder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  input  logic             c0,
  input  logic             in_valid,
  output logic [ADD_W-1:0] s,
  output logic             c,
  output logic             out_valid
);

  // w_carry[i] is the carry into stage i; w_carry[ADD_W] is the final carry-out.
  logic [ADD_W:0]   w_carry;
  logic [ADD_W-1:0] w_sum;
  add_res_t         w_res;

  add_res_t         r_res;
  logic             r_out_valid;

  assign w_carry[0] = c0;

  // Stage i consumes the carry produced by stage i-1; the ripple from c0 to
  // stage 7's carry-out is the critical path.
  for (genvar gi = 0; gi < ADD_W; gi++) begin : g_stage
    full_adder u_fa (
      .a    (a[gi]),
      .b    (b[gi]),
      .cin  (w_carry[gi]),
      .sum  (w_sum[gi]),
      .cout (w_carry[gi+1])
    );
  end

  assign w_res.c = w_carry[ADD_W];
  assign w_res.s = w_sum;

  // Capture the result on valid cycles, hold it otherwise; reset wins over load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_res <= w_res;
      end
    end
  end

  // Outputs come straight from flops so no input-to-output combinational path exists.
  assign s         = r_res.s;
  assign c         = r_res.c;
  assign out_valid = r_out_valid;

endmodule : rca_8bit_adder

// File: tb/tb_rca_8bit_adder.sv
// Self-checking bench for rca_8bit_adder: arithmetic reference model plus directed vectors.
// Latency: expects results one cycle after the operands are sampled.
// Backpressure: none to exercise; stimulus is applied every cycle.
module tb_rca_8bit_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       c0;
  logic       in_valid;
  logic [7:0] s;
  logic       c;
  logic       out_valid;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference state, derived from plain addition.
  logic [7:0] m_s;
  logic       m_c;
  logic       m_v;

  always #5 clk = ~clk;

  rca_8bit_adder dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .c0        (c0),
    .in_valid  (in_valid),
    .s         (s),
    .c         (c),
    .out_valid (out_valid)
  );

  // Reference model: a registered a + b + c0 with hold and synchronous reset.
  always @(posedge clk) begin
    if (rst) begin
      m_s <= 8'd0;
      m_c <= 1'b0;
      m_v <= 1'b0;
    end else if (in_valid) begin
      {m_c, m_s} <= 9'(a) + 9'(b) + 9'(c0);
      m_v        <= 1'b1;
    end else begin
      m_v <= 1'b0;
    end
  end

  // Every-cycle comparison of the DUT against the model, away from the edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      n_vec++;
      if ({c, s, out_valid} !== {m_c, m_s, m_v}) begin
        n_fail++;
        $display("FAIL model t=%0t: got c=%b s=%0d v=%b, expected c=%b s=%0d v=%b",
                 $time, c, s, out_valid, m_c, m_s, m_v);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] es, input logic ec, input logic ev);
    n_vec++;
    if (s !== es || c !== ec || out_valid !== ev) begin
      n_fail++;
      $display("FAIL %s: got c=%b s=%0d v=%b, expected c=%b s=%0d v=%b",
               name, c, s, out_valid, ec, es, ev);
    end
  endtask

  task automatic drive(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input logic tv, input logic tr);
    @(negedge clk);
    a        = ta;
    b        = tb;
    c0       = tc;
    in_valid = tv;
    rst      = tr;
  endtask

  task automatic add_chk(input string name, input logic [7:0] ta, input logic [7:0] tb,
                         input logic tc, input logic [7:0] es, input logic ec);
    drive(ta, tb, tc, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    chk(name, es, ec, 1'b1);
  endtask

  // Directed table: a, b, c0, expected s, expected c.
  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       c0;
    logic [7:0] s;
    logic       c;
  } vec_t;

  vec_t vecs[10] = '{
    '{"10+15+1",    8'd10,  8'd15,  1'b1, 8'd26,  1'b0},
    '{"100+105+0",  8'd100, 8'd105, 1'b0, 8'd205, 1'b0},
    '{"110+115+0",  8'd110, 8'd115, 1'b0, 8'd225, 1'b0},
    '{"108+125+0",  8'd108, 8'd125, 1'b0, 8'd233, 1'b0},
    '{"11+15+0",    8'd11,  8'd15,  1'b0, 8'd26,  1'b0},
    '{"115+140+0",  8'd115, 8'd140, 1'b0, 8'd255, 1'b0},
    '{"115+140+1",  8'd115, 8'd140, 1'b1, 8'd0,   1'b1},
    '{"255+255+1",  8'd255, 8'd255, 1'b1, 8'd255, 1'b1},
    '{"0+0+0",      8'd0,   8'd0,   1'b0, 8'd0,   1'b0},
    '{"255+0+1",    8'd255, 8'd0,   1'b1, 8'd0,   1'b1}
  };

  initial begin
    rst      = 1'b1;
    a        = 8'hA5;
    b        = 8'h5A;
    c0       = 1'b1;
    in_valid = 1'b1;

    // Reset held two cycles with valid, non-trivial operands present.
    @(posedge clk);
    #2;
    chk("reset_1", 8'd0, 1'b0, 1'b0);
    chk_en = 1'b1;
    drive(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    chk("reset_2", 8'd0, 1'b0, 1'b0);

    // Release with no valid input: outputs stay cleared.
    drive(8'h12, 8'h34, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("idle_after_reset", 8'd0, 1'b0, 1'b0);

    // Directed sums, carry ripple and extremes.
    foreach (vecs[i]) begin
      add_chk(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].c0, vecs[i].s, vecs[i].c);
    end

    // Back-to-back results, then hold when valid drops.
    add_chk("b2b_1", 8'd1,   8'd2,   1'b0, 8'd3,   1'b0);
    add_chk("b2b_2", 8'd200, 8'd100, 1'b0, 8'd44,  1'b1);
    add_chk("b2b_3", 8'd128, 8'd127, 1'b1, 8'd0,   1'b1);
    drive(8'd9, 8'd9, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("hold_1", 8'd0, 1'b1, 1'b0);
    drive(8'd77, 8'd3, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("hold_2", 8'd0, 1'b1, 1'b0);

    // Mid-stream reset discards the coincident operand; next valid input resumes.
    add_chk("pre_reset", 8'd50, 8'd60, 1'b0, 8'd110, 1'b0);
    drive(8'd1, 8'd1, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    chk("midstream_reset", 8'd0, 1'b0, 1'b0);
    add_chk("post_reset", 8'd20, 8'd22, 1'b0, 8'd42, 1'b0);

    // Random operands and valid pattern; the model process checks every cycle.
    for (int i = 0; i < 10000; i++) begin
      drive(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 199) == 0));
    end
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_rca_8bit_adder

// File: doc/rca_8bit_adder.md
# rca_8bit_adder

Registered 8-bit ripple-carry adder. It computes `a + b + c0`, producing an 8-bit sum and a carry-out. The result is captured in output registers on the clock edge. It is the basic arithmetic leaf block for datapaths that need a simple, area-minimal adder with a fixed one-cycle latency.

## Interface
Parameters:
- None. Width is fixed at 8 bits.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous and active-high.
- `a`  input  8  addend A, unsigned.
- `b`  input  8  addend B, unsigned.
- `c0`  input  1  carry-in.
- `in_valid`  input  1  qualifies `a`, `b` and `c0` on the current cycle.
- `s`  output  8  registered sum bits [7:0].
- `c`  output  1  registered carry-out (bit 8 of the result).
- `out_valid`  output  1  high when `s` and `c` hold a fresh result.

## Operation
- The combinational core is an 8-stage ripple chain of 1-bit full adders.
  - Stage 0 carry-in is `c0`.
  - Stage i carry-out feeds the carry-in of stage i+1.
  - Stage 7 carry-out is the carry result.
- Full-adder equations:
  - sum = a ^ b ^ cin
  - cout = (a & b) | (cin & (a ^ b))
- The 9-bit result `{c, s}` equals `a + b + c0` exactly. The maximum is 255 + 255 + 1 = 511, giving `s` = 0xFF and `c` = 1.
- There is no overflow flag. Signed interpretation is left to the consumer.
- When `in_valid` = 1 at a rising edge:
  - `s` and `c` load the core result.
  - `out_valid` is set to 1.
- When `in_valid` = 0 at a rising edge:
  - `s` and `c` hold their previous values.
  - `out_valid` is set to 0.
- There is no back-pressure and no ready signal. A new operand set is accepted on every valid cycle.

## Timing
- Latency is 1 cycle: operands sampled at edge N appear on `s`, `c` and `out_valid` after edge N.
- Throughput is one addition per cycle.
- Reset:
  - When `rst` = 1 at a rising edge, `s` = 0x00, `c` = 0 and `out_valid` = 0, regardless of `in_valid`.
  - Reset has priority over load.
- Reset mid-stream: an operand presented in the same cycle as `rst` is discarded. The first valid input after `rst` deasserts produces `out_valid` one cycle later.
- Outputs come directly from flops, with no combinational path from inputs to outputs.
- The critical path is the full 8-stage carry ripple from `c0` or bit 0 to the stage-7 carry-out.

## Structure
- No shared package is required. A width constant (8) may live in the team arithmetic package, but the port widths stay fixed.
- One sub-module: `full_adder` (a, b, cin -> sum, cout), instantiated 8 times in a generate loop or explicitly.
- The top level contains the ripple interconnect, the output/valid registers and the reset logic.

## Test plan
- Reset: assert `rst` for 2 cycles with arbitrary inputs and `in_valid` = 1 -> `s` = 0, `c` = 0, `out_valid` = 0. After release with `in_valid` = 0, the outputs stay at 0.
- Directed sums, each with `in_valid` = 1 and checked one cycle later:
  - 10 + 15 + c0=1 -> `s` = 26, `c` = 0
  - 100 + 105 + 0 -> `s` = 205, `c` = 0
  - 110 + 115 + 0 -> `s` = 225, `c` = 0
  - 108 + 125 + 0 -> `s` = 233, `c` = 0
  - 11 + 15 + 0 -> `s` = 26, `c` = 0
- Full carry ripple:
  - 115 + 140 + 0 -> `s` = 255, `c` = 0
  - 115 + 140 + 1 -> `s` = 0, `c` = 1
- Extremes:
  - 255 + 255 + 1 -> `s` = 255, `c` = 1
  - 0 + 0 + 0 -> `s` = 0, `c` = 0
  - 255 + 0 + 1 -> `s` = 0, `c` = 1
- Hold and back-to-back:
  - Three consecutive valid operand sets yield three consecutive results with `out_valid` high.
  - Then drop `in_valid` -> `out_valid` = 0 and `s`/`c` keep the last result.
- Random: 10k random `a`, `b`, `c0` with random `in_valid` -> `{c, s}` == `a + b + c0` one cycle after each valid input, compared against a reference model.
